// File: rtl/vcpu_pkg.sv
// Shared definitions for the vcpu1 pipeline: fetch FSM encoding and instruction constants.
package vcpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_ifid_reg.sv
// IF/ID pipeline register: holds by default, flush clears the instruction slot,
// load captures a freshly fetched instruction.
module ifid_reg
    import vcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic              i_pc_we,
    input  logic [31:0]       i_pc,
    input  logic [DATA_W-1:0] i_instr,
    output logic [31:0]       o_pc,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_valid
);

    logic [31:0]       r_pc;
    logic [DATA_W-1:0] r_instr;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_instr <= DATA_W'(NOP_INSTR);
            r_valid <= 1'b0;
        end else if (i_flush) begin
            // A flush may optionally retarget the slot's PC (redirect) or keep it (fault).
            r_instr <= DATA_W'(NOP_INSTR);
            r_valid <= 1'b0;
            if (i_pc_we) begin
                r_pc <= i_pc;
            end
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM, and feeds the IF/ID register.
module instr_fetch
    import vcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fetch_fault
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         w_load;
    logic         w_flush;
    logic         w_pc_we;
    logic [31:0]  w_ifid_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_pc_we     = 1'b0;
        w_ifid_pc_d = r_pc;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect && !is_word_aligned(redirect_pc)) begin
                    w_state_nxt = ST_FAULT;
                    w_flush     = 1'b1;
                end else if (redirect) begin
                    w_pc_nxt    = redirect_pc;
                    w_flush     = 1'b1;
                    w_pc_we     = 1'b1;
                    w_ifid_pc_d = redirect_pc;
                end else if (!stall) begin
                    w_load   = 1'b1;
                    w_pc_nxt = r_pc + INSTR_BYTES;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    ifid_reg #(
        .RESET_PC (RESET_PC),
        .DATA_W   (32)
    ) u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_pc_we (w_pc_we),
        .i_pc    (w_ifid_pc_d),
        .i_instr (rom_instr),
        .o_pc    (ifid_pc),
        .o_instr (ifid_instr),
        .o_valid (ifid_valid)
    );

    // ROM controls decode from registered state only, so no input reaches them combinationally.
    assign rom_en      = (r_state == ST_RUN);
    assign rom_addr    = r_pc;
    assign fetch_fault = (r_state == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small combinational ROM model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        fetch_fault;

    int checks;
    int failures;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_instr   (rom_instr),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr),
        .ifid_valid  (ifid_valid),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1234_5678;
            32'h0000_0004: return 32'h9ABC_DEF0;
            32'h0000_0008: return 32'h0BAD_F00D;
            32'h0000_000C: return 32'h1357_2468;
            32'h0000_0040: return 32'hCAFE_0040;
            32'h0000_0044: return 32'hCAFE_0044;
            32'h0000_0080: return 32'hBEEF_0080;
            32'hFFFF_FFFC: return 32'hFACE_FFFC;
            default:       return {16'hD00D, a[15:0]};
        endcase
    endfunction

    always_comb rom_instr = rom_en ? rom_word(rom_addr) : 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rom_en !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%0b exp=0", rom_en); end
        checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=00000000", rom_addr); end
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0) begin failures++; $display("FAIL reset_ifid got=%b/%h/%h exp=0/00000000/00000000", ifid_valid, ifid_pc, ifid_instr); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b exp=0", fetch_fault); end
        // BOOT ignores redirect: the redirect presented now must not move the PC.
        redirect = 1'b1; redirect_pc = 32'h0000_0080;
        step();
        redirect = 1'b0;
        checks++; if (rom_en !== 1'b1 || rom_addr !== 32'h0) begin failures++; $display("FAIL boot_ignore en=%0b addr=%h exp=1/00000000", rom_en, rom_addr); end
        checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%0b exp=0", ifid_valid); end
    endtask

    task automatic test_seq_fetch();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc = '{32'h0, 32'h4, 32'h8};
        exp_in = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D};
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc[i] || ifid_instr !== exp_in[i]) begin
                failures++;
                $display("FAIL seq_fetch[%0d] got=%b/%h/%h exp=1/%h/%h", i, ifid_valid, ifid_pc, ifid_instr, exp_pc[i], exp_in[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        checks++; if (ifid_pc !== 32'h4) begin failures++; $display("FAIL stall_setup got=%h exp=00000004", ifid_pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4 || ifid_instr !== 32'h9ABC_DEF0 || rom_addr !== 32'h8) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%b/%h/%h addr=%h exp=1/00000004/9abcdef0 addr=00000008", i, ifid_valid, ifid_pc, ifid_instr, rom_addr);
            end
        end
        stall = 1'b0;
        step();
        checks++; if (ifid_pc !== 32'h8 || ifid_instr !== 32'h0BAD_F00D || ifid_valid !== 1'b1) begin failures++; $display("FAIL stall_release got=%b/%h/%h exp=1/00000008/0badf00d", ifid_valid, ifid_pc, ifid_instr); end
        step();
        checks++; if (ifid_pc !== 32'hC || ifid_instr !== 32'h1357_2468) begin failures++; $display("FAIL stall_next got=%h/%h exp=0000000c/13572468", ifid_pc, ifid_instr); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        step(); step(); step();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect = 1'b0; stall = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || rom_addr !== 32'h40) begin failures++; $display("FAIL redir_bubble got=%b/%h addr=%h exp=0/00000000 addr=00000040", ifid_valid, ifid_instr, rom_addr); end
        step();
        checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40 || ifid_instr !== 32'hCAFE_0040) begin failures++; $display("FAIL redir_target got=%b/%h/%h exp=1/00000040/cafe0040", ifid_valid, ifid_pc, ifid_instr); end
        step();
        checks++; if (ifid_pc !== 32'h44 || ifid_instr !== 32'hCAFE_0044) begin failures++; $display("FAIL redir_next got=%h/%h exp=00000044/cafe0044", ifid_pc, ifid_instr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect_pc = 32'h0000_0080;
        step();
        redirect = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h80 || rom_addr !== 32'h80) begin failures++; $display("FAIL b2b_second got=%b/%h addr=%h exp=0/00000080 addr=00000080", ifid_valid, ifid_pc, rom_addr); end
        step();
        checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h80 || ifid_instr !== 32'hBEEF_0080) begin failures++; $display("FAIL b2b_target got=%b/%h/%h exp=1/00000080/beef0080", ifid_valid, ifid_pc, ifid_instr); end
    endtask

    task automatic test_fault();
        do_reset();
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h0000_0042;
        step();
        checks++; if (fetch_fault !== 1'b1 || rom_en !== 1'b0) begin failures++; $display("FAIL fault_enter fault=%0b en=%0b exp=1/0", fetch_fault, rom_en); end
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0 || rom_addr !== 32'h4) begin failures++; $display("FAIL fault_ifid got=%b/%h/%h addr=%h exp=0/00000000/00000000 addr=00000004", ifid_valid, ifid_pc, ifid_instr, rom_addr); end
        // FAULT must ignore further redirects and stalls.
        redirect_pc = 32'h0000_0040;
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            step();
            checks++;
            if (fetch_fault !== 1'b1 || rom_en !== 1'b0 || ifid_valid !== 1'b0 || rom_addr !== 32'h4) begin
                failures++;
                $display("FAIL fault_hold[%0d] fault=%0b en=%0b valid=%0b addr=%h exp=1/0/0/00000004", i, fetch_fault, rom_en, ifid_valid, rom_addr);
            end
        end
        redirect = 1'b0; stall = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (fetch_fault !== 1'b0 || rom_addr !== 32'h0) begin failures++; $display("FAIL fault_clear fault=%0b addr=%h exp=0/00000000", fetch_fault, rom_addr); end
        step(); step();
        checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== 32'h1234_5678) begin failures++; $display("FAIL fault_restart got=%b/%h/%h exp=1/00000000/12345678", ifid_valid, ifid_pc, ifid_instr); end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        checks++; if (rom_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_target got=%h exp=fffffffc", rom_addr); end
        step();
        checks++; if (rom_addr !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC || ifid_instr !== 32'hFACE_FFFC) begin failures++; $display("FAIL wrap_next addr=%h ifid=%h/%h exp=00000000 fffffffc/facefffc", rom_addr, ifid_pc, ifid_instr); end
        step();
        checks++; if (ifid_pc !== 32'h0 || ifid_instr !== 32'h1234_5678) begin failures++; $display("FAIL wrap_fetch got=%h/%h exp=00000000/12345678", ifid_pc, ifid_instr); end
    endtask

    task automatic test_reset_mid_redirect();
        do_reset();
        step(); step(); step();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0080;
        step();
        rst = 1'b0; redirect = 1'b0;
        checks++; if (rom_en !== 1'b0 || rom_addr !== 32'h0 || fetch_fault !== 1'b0) begin failures++; $display("FAIL rstredir_rom en=%0b addr=%h fault=%0b exp=0/00000000/0", rom_en, rom_addr, fetch_fault); end
        checks++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== 32'h0) begin failures++; $display("FAIL rstredir_ifid got=%b/%h/%h exp=0/00000000/00000000", ifid_valid, ifid_pc, ifid_instr); end
        step(); step();
        checks++; if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1) begin failures++; $display("FAIL rstredir_restart got=%b/%h exp=1/00000000", ifid_valid, ifid_pc); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_seq_fetch();
        test_stall();
        test_redirect_stall();
        test_back_to_back();
        test_fault();
        test_wrap();
        test_reset_mid_redirect();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the vcpu1 pipeline. Owns the program counter and drives the instruction ROM's enable and address each cycle. Captures the ROM's combinational, big-endian 32-bit word into the IF/ID pipeline register for the decode stage. Handles stalls from downstream, branch/jump redirects, and misaligned-target faults.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: decode cannot accept; hold PC and IF/ID contents.
- `redirect` in 1: branch/jump taken; load `redirect_pc` and squash the in-flight fetch.
- `redirect_pc` in 32: redirect target byte address.
- `rom_en` out 1: ROM enable.
- `rom_addr` out 32: ROM byte address, always equal to the current PC.
- `rom_instr` in 32: ROM read data, combinational from `rom_addr`; reads 0 (NOP) when `rom_en`=0.
- `ifid_pc` out 32: PC of the instruction held in IF/ID.
- `ifid_instr` out 32: instruction held in IF/ID.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `fetch_fault` out 1: sticky flag for a misaligned redirect.

## Operation
- FSM states: BOOT, RUN, FAULT.
- BOOT:
  - Entered on `rst`. Lasts exactly one cycle, then moves to RUN.
  - `rom_en`=0; `redirect` and `stall` are ignored.
- RUN:
  - `rom_en`=1 and `rom_addr`=pc.
  - Each rising edge applies the first matching rule in priority order below.
- Rule 1, `redirect`=1 with `redirect_pc[1:0]`≠0:
  - Go to FAULT; `fetch_fault`←1.
  - `ifid_valid`←0 and `ifid_instr`←0.
  - pc is unchanged.
- Rule 2, `redirect`=1 with an aligned target:
  - pc←`redirect_pc`.
  - `ifid_valid`←0, `ifid_instr`←0, `ifid_pc`←`redirect_pc`.
  - Redirect overrides `stall`.
- Rule 3, `stall`=1: pc and all `ifid_*` hold.
- Rule 4, otherwise:
  - `ifid_instr`←`rom_instr`, `ifid_pc`←pc, `ifid_valid`←1.
  - pc←pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- FAULT:
  - `rom_en`=0; pc and `ifid_*` hold, with `ifid_valid`=0.
  - `fetch_fault` stays 1. Only `rst` leaves this state.
- Alignment: pc[1:0] is always 00. Aligned values come from `RESET_PC`, +4 increments and validated redirects.
- PC width is a full 32 bits. Out-of-range addresses are the ROM's concern, not this block's.

## Timing
- Reset values, all forced by `rst` on the edge:
  - state=BOOT, pc=`RESET_PC`, `rom_en`=0, `rom_addr`=`RESET_PC`.
  - `ifid_pc`=`RESET_PC`, `ifid_instr`=0, `ifid_valid`=0, `fetch_fault`=0.
- `rst` overrides every other input in every state, including mid-stall and FAULT.
- `rom_en` and `rom_addr` are registered-state decodes: a function of state and pc only, with no path from inputs.
- Fetch latency: one cycle from pc to `ifid_instr`.
- First valid instruction: edge 0 asserts reset, edge 1 is BOOT→RUN, edge 2 sets `ifid_valid`=1 with `ifid_pc`=`RESET_PC`.
- Redirect penalty: one bubble. Taken on edge N, the target is fetched during cycle N+1 and appears in IF/ID after edge N+1.
- Back-to-back redirects: each one takes effect, and the last one wins.
- Stall released: fetch resumes from the held pc with no lost or duplicated instruction.

## Structure
- Shared package `vcpu_pkg` holds:
  - the FSM state encoding (BOOT/RUN/FAULT, 2 bits);
  - `NOP_INSTR` = 32'h0;
  - `INSTR_BYTES` = 4, used as the PC increment.
- One sub-module, `ifid_reg`: the IF/ID pipeline register with hold, flush and load controls. The PC/FSM logic stays in `instr_fetch`.

## Test plan
- Reset, `RESET_PC`=0, ROM preloaded with words at 0x0/0x4/0x8, no stall:
  - `ifid_valid` rises at edge 2.
  - `ifid_pc` sequence is 0x0, 0x4, 0x8, with matching `ifid_instr` big-endian words.
- `stall` held for 3 cycles while IF/ID holds pc 0x4:
  - `ifid_*` unchanged for all 3 cycles.
  - After release, 0x8 follows with no gap or duplicate.
- `redirect`=1, `redirect_pc`=0x40, while `stall`=1:
  - Next cycle `ifid_valid`=0 and `ifid_instr`=0.
  - The following cycle `ifid_pc`=0x40 with valid=1.
- `redirect_pc`=0x42:
  - `fetch_fault`=1, `rom_en`=0, `ifid_valid`=0, held for 10 cycles.
  - `rst` clears the fault and fetch restarts at `RESET_PC`.
- pc forced to 0xFFFF_FFFC via redirect: the next fetch address is 0x0000_0000.
- `rst` asserted mid-run during a redirect: all outputs return to reset values on that edge, and the redirect is discarded.
